// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- fetch stage of the rv32i core.
//
// Holds the fetch PC, issues one word read at a time to instruction memory,
// buffers returned words in a small FIFO and hands {instr, pc, opcode} to the
// main decoder under a valid/ready handshake. A redirect (taken branch/jump)
// flushes the buffer and cancels any outstanding memory read.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   imemReqValid/Ready, imemAddr word-read request channel to memory
//   imemRspValid, imemRspData    response channel (no backpressure)
//   instrValid/Ready             handshake toward decode
//   instr, instrPc, op           FIFO head word, its PC, and opcode field
//   redirect, redirectPc         1-cycle redirect pulse and its target PC
//   fetchCount, dropCount        perf counters (only with FETCH_PERF_EN)
//
// Build option: define FETCH_PERF_EN to add the fetchCount/dropCount outputs.
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemAddr,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic [6:0]  op,
    input  logic        redirect,
    input  logic [31:0] redirectPc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] dropCount
`endif
);

    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      instr_mem_q [FIFO_DEPTH];
    logic [31:0]      instr_mem_d [FIFO_DEPTH];
    logic [31:0]      pc_mem_q    [FIFO_DEPTH];
    logic [31:0]      pc_mem_d    [FIFO_DEPTH];

    logic             req_valid_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_nonempty_s;

    // Request channel and fetch FSM next-state; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        push_s  = 1'b0;

        // rst_n gating keeps the request low while reset is held, not just after.
        req_valid_s = rst_n && (state_q == ST_REQ) && (count_q < DEPTH_C) && !redirect;

        case (state_q)
            ST_REQ: begin
                if (req_valid_s && imemReqReady) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imemRspValid) begin
                    // A same-cycle redirect makes this response stale.
                    push_s  = !redirect;
                    state_d = ST_REQ;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imemRspValid) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (redirect) begin
            pc_d = redirectPc & WORD_MASK;
        end else if (push_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

    // Instruction buffer: pointers, occupancy and entry writes.
    always_comb begin
        instr_mem_d     = instr_mem_q;
        pc_mem_d        = pc_mem_q;
        fifo_nonempty_s = (count_q != CNT_ZERO);
        // A pop coinciding with a redirect is void: the flush wins.
        pop_s           = fifo_nonempty_s && instrReady && !redirect;

        if (push_s) begin
            instr_mem_d[wr_ptr_q] = imemRspData;
            pc_mem_d[wr_ptr_q]    = pc_q;
        end else begin
            instr_mem_d = instr_mem_q;
            pc_mem_d    = pc_mem_q;
        end

        if (redirect) begin
            count_d  = CNT_ZERO;
            rd_ptr_d = PTR_ZERO;
            wr_ptr_d = PTR_ZERO;
        end else begin
            rd_ptr_d = pop_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
            wr_ptr_d = push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State, PC and buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC & WORD_MASK;
            count_q  <= CNT_ZERO;
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= 32'h0000_0000;
                pc_mem_q[i]    <= 32'h0000_0000;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    // Output drive: head comes only from registered storage, NOP when empty.
    always_comb begin
        imemReqValid = req_valid_s;
        imemAddr     = pc_q;
        instrValid   = fifo_nonempty_s;
        if (fifo_nonempty_s) begin
            instr   = instr_mem_q[rd_ptr_q];
            instrPc = pc_mem_q[rd_ptr_q];
        end else begin
            instr   = NOP_INSTR;
            instrPc = 32'h0000_0000;
        end
        op = instr[6:0];
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        rsp_discard_s;

    // Perf counters: pushes, plus discarded responses and flushed entries.
    always_comb begin
        rsp_discard_s = imemRspValid &&
                        ((state_q == ST_DROP) || ((state_q == ST_WAIT) && redirect));
        fetch_cnt_d   = push_s ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        drop_cnt_d    = drop_cnt_q
                      + (rsp_discard_s ? 32'd1 : 32'd0)
                      + (redirect ? 32'(count_q) : 32'd0);
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            drop_cnt_q  <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign fetchCount = fetch_cnt_q;
    assign dropCount  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch -- randomized self-checking bench for instr_fetch.
//
// A driver process plays memory and decode, keeps a transaction-level model
// (fetch PC, one outstanding read, queue of expected {pc, word}) and checks the
// request channel. A separate monitor compares the decode-side head against
// the front of the expected queue and pops it on each accepted handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;
    localparam int          CYCLES = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemAddr;
    logic        imemRspValid;
    logic [31:0] imemRspData;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic [6:0]  op;
    logic        redirect;
    logic [31:0] redirectPc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] dropCount;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imemReqValid (imemReqValid),
        .imemReqReady (imemReqReady),
        .imemAddr     (imemAddr),
        .imemRspValid (imemRspValid),
        .imemRspData  (imemRspData),
        .instrValid   (instrValid),
        .instrReady   (instrReady),
        .instr        (instr),
        .instrPc      (instrPc),
        .op           (op),
        .redirect     (redirect),
        .redirectPc   (redirectPc)
`ifdef FETCH_PERF_EN
        ,
        .fetchCount   (fetchCount),
        .dropCount    (dropCount)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          pops        = 0;

    // Transaction-level model state
    logic [31:0] model_pc;
    bit          outstanding;
    bit          cancelled;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    int          timer;
    logic [31:0] exp_fetch;
    logic [31:0] exp_drop;

    // Values seen during the current cycle, applied at the next edge
    logic        cap_req_valid, cap_req_ready, cap_rsp_valid, cap_redirect;
    logic [31:0] cap_redirect_pc;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pc    = RST_PC;
        outstanding = 1'b0;
        cancelled   = 1'b0;
        timer       = 0;
        exp_fetch   = 32'd0;
        exp_drop    = 32'd0;
    endtask

    task automatic check_idle_outputs();
        check32("reset_reqValid", {31'd0, imemReqValid}, 32'd0);
        check32("reset_instrValid", {31'd0, instrValid}, 32'd0);
        check32("reset_instr", instr, 32'h0000_0013);
        check32("reset_instrPc", instrPc, 32'd0);
        check32("reset_op", {25'd0, op}, 32'd19);
`ifdef FETCH_PERF_EN
        check32("reset_fetchCount", fetchCount, 32'd0);
        check32("reset_dropCount", dropCount, 32'd0);
`endif
    endtask

    task automatic drive(input int ready_pct);
        instrReady   = ($urandom_range(0, 99) < ready_pct);
        imemReqReady = ($urandom_range(0, 99) < 70);
        redirect     = ($urandom_range(0, 15) == 0);
        redirectPc   = $urandom & 32'h0000_0FFF;
        if (outstanding && timer <= 1) begin
            imemRspValid = 1'b1;
            imemRspData  = out_data;
        end else begin
            imemRspValid = 1'b0;
            imemRspData  = $urandom;
            if (outstanding) timer--;
        end
    endtask

    task automatic sample();
        bit exp_rv;
        cap_req_valid   = imemReqValid;
        cap_req_ready   = imemReqReady;
        cap_rsp_valid   = imemRspValid;
        cap_redirect    = redirect;
        cap_redirect_pc = redirectPc;
        exp_rv = !outstanding && (exp_q.size() < DEPTH) && !redirect;
        check32("imemReqValid", {31'd0, imemReqValid}, {31'd0, exp_rv});
        if (imemReqValid) check32("imemAddr", imemAddr, model_pc);
    endtask

    task automatic update();
        if (cap_rsp_valid) begin
            if (!cancelled && !cap_redirect) begin
                exp_q.push_back('{pc: out_addr, data: out_data});
                model_pc  = out_addr + 32'd4;
                exp_fetch = exp_fetch + 32'd1;
            end else begin
                exp_drop = exp_drop + 32'd1;
            end
            outstanding = 1'b0;
        end
        if (cap_redirect) begin
            exp_drop = exp_drop + 32'(exp_q.size());
            exp_q.delete();
            model_pc = cap_redirect_pc & 32'hFFFF_FFFC;
            if (outstanding) cancelled = 1'b1;
        end
        if (cap_req_valid && cap_req_ready) begin
            outstanding = 1'b1;
            cancelled   = 1'b0;
            out_addr    = model_pc;
            out_data    = $urandom;
            timer       = $urandom_range(1, 3);
        end
    endtask

    // Driver: reset, random traffic with one mid-transaction reset, summary.
    initial begin
        bit did_reset = 1'b0;
        rst_n        = 1'b0;
        imemReqReady = 1'b0;
        imemRspValid = 1'b0;
        imemRspData  = 32'd0;
        instrReady   = 1'b0;
        redirect     = 1'b0;
        redirectPc   = 32'd0;
        model_reset();
        #1;
        check_idle_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            if (!did_reset && cyc > CYCLES / 2 && outstanding && !cancelled) begin
                did_reset    = 1'b1;
                rst_n        = 1'b0;
                redirect     = 1'b0;
                imemRspValid = 1'b0;
                imemReqReady = 1'b0;
                #1;
                check_idle_outputs();
                model_reset();
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            // Decode readiness cycles through mostly-ready, stalled and mixed phases.
            case ((cyc / 250) % 3)
                0:       drive(90);
                1:       drive(5);
                default: drive(50);
            endcase
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
            update();
        end
`ifdef FETCH_PERF_EN
        check32("fetchCount", fetchCount, exp_fetch);
        check32("dropCount", dropCount, exp_drop);
`endif
        vectors++;
        if (pops == 0) begin
            miscompares++;
            $display("FAIL decode_handshakes: got %0d, expected nonzero", pops);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: compare decode-side head with the scoreboard; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                check32("instrValid", {31'd0, instrValid}, {31'd0, (exp_q.size() != 0)});
                if (exp_q.size() != 0) begin
                    check32("instr", instr, exp_q[0].data);
                    check32("instrPc", instrPc, exp_q[0].pc);
                    check32("op", {25'd0, op}, {25'd0, exp_q[0].data[6:0]});
                    if (instrReady && !redirect) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end else begin
                    check32("empty_instr", instr, 32'h0000_0013);
                    check32("empty_instrPc", instrPc, 32'd0);
                end
            end
        end
    end

endmodule
